serial_subtractor_4b: RTL and testbench

Bit-serial, multi-cycle subtractor computing diff = a - b (mod 2^nbits) plus a final borrow flag, one bit per cycle, LSB first.
- Inverse-direction counterpart of the team's combinational 4-bit adder; a - b + b must reproduce a through that adder.
- Uses val/rdy handshakes on input and output; sits between a request producer and a result consumer.

---
 rtl/serial_subtractor_4b_pkg.sv | 17 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor_4b.sv | 97 +++++++++
 tb/tb_serial_subtractor_4b.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_4b_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_4b_pkg;

  localparam int DEFAULT_NBITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be able to hold the value nbits.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_4b.sv
// Bit-serial subtractor, LSB first, with val/rdy handshakes on both sides.
module serial_subtractor_4b
  import serial_subtractor_4b_pkg::*;
#(
  parameter int nbits = DEFAULT_NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_a,
  input  logic [nbits-1:0] in_b,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_diff,
  output logic             out_borrow
);

  localparam int cnt_w = cnt_width(nbits);

  state_t             state_q, state_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic [nbits-1:0]   a_q, a_d;
  logic [nbits-1:0]   b_q, b_d;
  logic [nbits-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic               d_bit;
  logic               bout_bit;

  full_subtractor u_full_subtractor (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned and infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    unique case (state_q)
      IDLE: begin
        if (in_val) begin
          a_d      = in_a;
          b_d      = in_b;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = {d_bit, res_q[nbits-1:1]};
        borrow_d = bout_bit;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == cnt_w'(nbits - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath shift registers are reset too, because out_diff and out_borrow come straight from them and must read zero in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values regardless of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
    end
  end

  assign in_rdy     = (state_q == IDLE) && !rst;
  assign out_val    = (state_q == DONE);
  assign out_diff   = res_q;
  assign out_borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_4b.sv
// Scoreboard bench: driver pushes expected ops on acceptance, monitor pops on each consumed result.
module tb_serial_subtractor_4b;

  localparam int NB   = 4;
  localparam int MASK = (1 << NB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_val = 1'b0;
  logic          out_rdy = 1'b0;
  logic [NB-1:0] in_a = '0;
  logic [NB-1:0] in_b = '0;
  logic          in_rdy;
  logic          out_val;
  logic          out_borrow;
  logic [NB-1:0] out_diff;

  typedef struct {
    int a;
    int b;
    int acc;
  } op_t;

  op_t  sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   rise_cyc = 0;
  logic prev_val = 1'b0;
  logic rnd_phase = 1'b0;

  serial_subtractor_4b #(.nbits(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_diff   (out_diff),
    .out_borrow (out_borrow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: a result is consumed at the posedge following a sample with out_val && out_rdy.
  initial forever begin
    op_t e;
    int  exp_d;
    int  exp_b;
    @(negedge clk);
    #1;
    if (out_val && !prev_val) rise_cyc = cyc;
    prev_val = out_val;
    if (out_val && out_rdy && !rst) begin
      check("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e     = sb.pop_front();
        exp_d = (e.a - e.b) & MASK;
        exp_b = (e.a < e.b) ? 1 : 0;
        check("diff", int'(out_diff), exp_d);
        check("borrow", int'(out_borrow), exp_b);
        check("adder_roundtrip", (int'(out_diff) + e.b) & MASK, e.a);
        check("latency", rise_cyc - e.acc, NB);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rnd_phase) out_rdy = 1'($urandom_range(0, 1));
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int a, input int b, output int acc);
    in_a   = NB'(a);
    in_b   = NB'(b);
    in_val = 1'b1;
    acc    = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_rdy) begin
        acc = cyc + 1;
        sb.push_back('{a, b, acc});
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check("accept_timeout", 0, 1);
    else @(negedge clk);
    in_val = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && in_rdy) break;
    end
    check("drain", int'(sb.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int prev_acc;
    int pa[8] = '{15, 0, 10, 5, 15, 0, 10, 15};
    int pb[8] = '{0, 15, 5, 10, 15, 0, 10, 5};

    // Reset state
    @(negedge clk);
    #1;
    check("rst_out_val", int'(out_val), 0);
    check("rst_out_diff", int'(out_diff), 0);
    check("rst_out_borrow", int'(out_borrow), 0);
    check("rst_in_rdy", int'(in_rdy), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_rdy", int'(in_rdy), 1);
    @(negedge clk);

    // 0 - 0 with in_rdy low throughout CALC and DONE
    out_rdy = 1'b1;
    send(0, 0, acc);
    for (int i = 0; i < NB + 1; i++) begin
      #1;
      check("busy_in_rdy", int'(in_rdy), 0);
      @(negedge clk);
    end
    #1;
    check("in_rdy_after_hs", int'(in_rdy), 1);
    @(negedge clk);

    // Directed non-wrapping and wrapping cases
    send(12, 7, acc);
    send(15, 8, acc);
    send(15, 15, acc);
    send(0, 1, acc);
    send(8, 9, acc);
    send(1, 8, acc);
    drain();

    // Backpressure: result held, new request ignored until consumed
    out_rdy = 1'b0;
    send(5, 7, acc);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (out_val) break;
    end
    check("bp_out_val_rise", int'(out_val), 1);
    @(negedge clk);
    in_a   = 4'd3;
    in_b   = 4'd1;
    in_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_out_val", int'(out_val), 1);
      check("bp_diff", int'(out_diff), 14);
      check("bp_borrow", int'(out_borrow), 1);
      check("bp_in_rdy", int'(in_rdy), 0);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    send(3, 1, acc);
    drain();

    // Reset during the second CALC cycle
    send(9, 3, acc);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_out_val", int'(out_val), 0);
    check("midrst_diff", int'(out_diff), 0);
    check("midrst_borrow", int'(out_borrow), 0);
    check("midrst_in_rdy", int'(in_rdy), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NB + 4; i++) begin
      #1;
      check("post_rst_no_val", int'(out_val), 0);
      @(negedge clk);
    end
    send(6, 2, acc);
    drain();

    // Back-to-back with fixed spacing
    prev_acc = -1;
    for (int i = 0; i < 8; i++) begin
      send(pa[i], pb[i], acc);
      if (prev_acc >= 0) check("b2b_spacing", acc - prev_acc, NB + 2);
      prev_acc = acc;
    end
    drain();

    // Random operands, random gaps and random consumer stalls
    rnd_phase = 1'b1;
    for (int i = 0; i < 24; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, MASK));
      b = int'($urandom_range(0, MASK));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(a, b, acc);
    end
    rnd_phase = 1'b0;
    out_rdy   = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
